// File: rtl/key_serializer.sv
// Serial driver for the key-check FSM: shifts a parallel key out MSB-first on x,
// waits RESP_LAT cycles, samples the FSM result and counts failed attempts.
module key_serializer #(
  parameter int   KEY_W    = 5,
  parameter logic IDLE_BIT = 1'b1,
  parameter int   RESP_LAT = 1,
  parameter int   CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_valid,
  output logic             key_ready,
  output logic             x,
  output logic             busy,
  input  logic             fsm_out,
  output logic             result_valid,
  output logic             result_pass,
  output logic [CNT_W-1:0] fail_cnt
);

  localparam int BW = $clog2(KEY_W + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(KEY_W);
  localparam logic [3:0]    WAIT_LAST = 4'(RESP_LAT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t           state;
  logic [KEY_W-1:0] shreg;
  logic [BW-1:0]    bitcnt;
  logic [3:0]       waitcnt;

  assign key_ready = (state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      x            <= IDLE_BIT;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result_pass  <= 1'b0;
      fail_cnt     <= '0;
      shreg        <= '0;
      bitcnt       <= '0;
      waitcnt      <= '0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (key_valid) begin
            shreg  <= key_in;
            x      <= key_in[KEY_W-1];
            bitcnt <= BW'(1);
            busy   <= 1'b1;
            state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (bitcnt == BIT_LAST) begin
            x       <= IDLE_BIT;
            waitcnt <= 4'd1;
            state   <= ST_WAIT;
          end else begin
            // MSB already on x; the bit below it is the next to present
            x      <= shreg[KEY_W-2];
            shreg  <= {shreg[KEY_W-2:0], 1'b0};
            bitcnt <= bitcnt + 1'b1;
          end
        end
        ST_WAIT: begin
          if (waitcnt == WAIT_LAST) begin
            result_pass  <= fsm_out;
            result_valid <= 1'b1;
            if (!fsm_out && (fail_cnt != '1))
              fail_cnt <= fail_cnt + 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            waitcnt <= waitcnt + 1'b1;
          end
        end
        default: begin
          x     <= IDLE_BIT;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_serializer.sv
// Scoreboard bench for key_serializer with a behavioural key-check FSM stand-in
// (prefix matcher for 5'b11110 that latches unlocked or blackholed until fsm_rst).
module tb_key_serializer;

  localparam int   KEY_W    = 5;
  localparam int   RESP_LAT = 1;
  localparam logic IDLE_BIT = 1'b1;
  localparam logic [KEY_W-1:0] GOOD_KEY = 5'b11110;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             fsm_rst = 1'b1;
  logic             key_valid = 1'b0;
  logic [KEY_W-1:0] key_in = '0;
  logic             fsm_out;

  logic       key_ready, x, busy, result_valid, result_pass;
  logic [7:0] fail_cnt;
  logic       key_ready2, x2, busy2, result_valid2, result_pass2;
  logic [1:0] fail_cnt2;

  key_serializer #(.KEY_W(KEY_W), .IDLE_BIT(IDLE_BIT), .RESP_LAT(RESP_LAT), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
    .x(x), .busy(busy), .fsm_out(fsm_out), .result_valid(result_valid),
    .result_pass(result_pass), .fail_cnt(fail_cnt)
  );

  key_serializer #(.KEY_W(KEY_W), .IDLE_BIT(IDLE_BIT), .RESP_LAT(RESP_LAT), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready2),
    .x(x2), .busy(busy2), .fsm_out(fsm_out), .result_valid(result_valid2),
    .result_pass(result_pass2), .fail_cnt(fail_cnt2)
  );

  always #10 clk = ~clk;

  // FSM stand-in driven by the primary DUT's x
  int   mcnt = 0;
  logic bh = 1'b0, unl = 1'b0;
  always @(posedge clk) begin
    if (fsm_rst) begin
      mcnt <= 0; bh <= 1'b0; unl <= 1'b0;
    end else if (!bh && !unl) begin
      if (x == GOOD_KEY[KEY_W-1-mcnt]) begin
        if (mcnt == KEY_W-1) unl <= 1'b1;
        mcnt <= mcnt + 1;
      end else begin
        bh <= 1'b1;
      end
    end
  end
  assign fsm_out = unl;

  int errors = 0;
  int checks = 0;

  typedef struct { logic pass; int raw; } exp_t;
  exp_t             sb[$];
  logic [KEY_W-1:0] keyq[$];

  // Attempt-level model: 0 = fresh FSM, 1 = unlocked, 2 = blackholed
  int fsm_st     = 0;
  int raw_fails  = 0;
  bit must_fresh = 1'b1;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic issue(input logic [KEY_W-1:0] k, input logic fresh, output int waited);
    exp_t e;
    logic p;
    key_in = k;
    key_valid = 1'b1;
    waited = 0;
    while (!key_ready && waited < 200) begin
      @(negedge clk); #1;
      waited++;
    end
    if (!key_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: key_ready never rose, got 0 expected 1 at %0t", $time);
      key_valid = 1'b0;
      return;
    end
    fsm_rst = fresh;
    if (fresh) fsm_st = 0;
    if (fsm_st == 0) begin
      p = (k == GOOD_KEY);
      fsm_st = p ? 1 : 2;
    end else begin
      p = (fsm_st == 1);
    end
    if (!p) raw_fails++;
    e.pass = p;
    e.raw  = raw_fails;
    sb.push_back(e);
    keyq.push_back(k);
    @(negedge clk); #1;
    key_valid = 1'b0;
    fsm_rst = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    sb.delete();
    keyq.delete();
    raw_fails = 0;
    must_fresh = 1'b1;
    repeat (n) begin @(negedge clk); #1; end
    rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
    end
    repeat (2) begin @(negedge clk); #1; end
  endtask

  // Monitor
  logic rst_at_edge = 1'b0;
  always @(posedge clk) rst_at_edge <= rst;

  initial begin
    bit               started;
    logic             prev_busy, exp_rv, exp_x, rise;
    int               k;
    logic [KEY_W-1:0] cur;
    exp_t             e;
    started = 1'b0; prev_busy = 1'b0; k = 0; cur = '0;
    forever begin
      @(negedge clk);
      if (rst_at_edge) begin
        started = 1'b1;
        check("rst_x", x, IDLE_BIT);
        check("rst_key_ready", key_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_result_pass", result_pass, 0);
        check("rst_fail_cnt", fail_cnt, 0);
        check("rst_fail_cnt2", fail_cnt2, 0);
        prev_busy = 1'b0; k = 0;
      end else if (started) begin
        exp_rv = prev_busy && !busy;
        rise   = busy && !prev_busy;
        check("result_valid", result_valid, exp_rv);
        check("result_valid2", result_valid2, exp_rv);
        if (exp_rv) begin
          check("busy_len", k, KEY_W + RESP_LAT);
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_result: got result with empty scoreboard at %0t", $time);
          end else begin
            e = sb.pop_front();
            check("result_pass", result_pass, e.pass);
            check("result_pass2", result_pass2, e.pass);
            check("fail_cnt", fail_cnt, sat(e.raw, 255));
            check("fail_cnt2", fail_cnt2, sat(e.raw, 3));
          end
        end
        if (rise) begin
          if (keyq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_start: busy rose with no key issued at %0t", $time);
            cur = '0;
          end else begin
            cur = keyq.pop_front();
          end
          k = 0;
        end
        if (busy) begin
          exp_x = (k < KEY_W) ? cur[KEY_W-1-k] : IDLE_BIT;
          k++;
        end else begin
          exp_x = IDLE_BIT;
        end
        check("x", x, exp_x);
        check("x2", x2, exp_x);
        check("key_ready", key_ready, !busy);
        check("key_ready2", key_ready2, !busy);
        check("busy2", busy2, busy);
        prev_busy = busy;
      end
    end
  end

  // Stimulus
  initial begin
    int w;
    int gap;
    logic [KEY_W-1:0] k;
    logic fresh;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    fsm_rst = 1'b0;
    repeat (2) begin @(negedge clk); #1; end

    // correct key on a fresh FSM
    issue(GOOD_KEY, 1'b1, w);
    must_fresh = 1'b0;
    drain();

    // wrong key blackholes the FSM; correct key afterwards still fails
    issue(5'b00001, 1'b1, w);
    drain();
    issue(GOOD_KEY, 1'b0, w);
    drain();

    // second key held valid through the first attempt
    issue(GOOD_KEY, 1'b1, w);
    issue(5'b01010, 1'b0, w);
    check("held_wait", w, KEY_W + RESP_LAT);
    drain();

    // reset in the third SHIFT cycle aborts the attempt
    issue(5'b10110, 1'b1, w);
    @(negedge clk); #1;
    @(negedge clk); #1;
    do_reset(1);
    repeat (12) begin @(negedge clk); #1; end

    // five failing attempts: narrow counter saturates
    for (int i = 0; i < 5; i++) begin
      issue(5'b00001, 1'b1, w);
      must_fresh = 1'b0;
      drain();
    end

    do_reset(2);
    for (int i = 0; i < 60; i++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin @(negedge clk); #1; end
      k = ($urandom_range(0, 2) == 0) ? GOOD_KEY : KEY_W'($urandom);
      fresh = must_fresh || ($urandom_range(0, 1) == 1);
      must_fresh = 1'b0;
      issue(k, fresh, w);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
